// File: rtl/gcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gcd_pkg
// Description : Shared definitions for the GCD result path. Holds the default
//               result width and buffer depth, the drop-counter width, and the
//               per-cycle buffer operation encoding used by the collector.
// Revision    : 1.0 - initial release
// ============================================================================
package gcd_pkg;

    localparam int GCD_WIDTH = 4;   // GCD result data width
    localparam int RES_DEPTH = 4;   // result buffer entries (power of two)
    localparam int DROP_W    = 8;   // overflow drop counter width

    // Buffer activity in a single cycle.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e fifo_op(input logic push, input logic pop);
        return fifo_op_e'({push, pop});
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up counter that sticks at its all-ones value.
// Ports       : clk_i   - clock, rising edge
//               rst_ni  - asynchronous active-low reset, clears the count
//               inc_i   - increment enable
//               count_o - current count value
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
    import gcd_pkg::*;
#(
    parameter int WIDTH = DROP_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= '0;
        end else if (inc_i && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count_o = r_count;

endmodule
`default_nettype wire

// File: rtl/gcd_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : gcd_result_collector
// Description : Captures GCD results on the rising edge of res_valid_i and
//               queues them in a first-word-fall-through buffer. Results that
//               arrive while the buffer is full (and nothing leaves that cycle)
//               are dropped and counted. A sticky flag records any accepted
//               zero result.
// Ports       : clk_i        - clock, rising edge
//               rst_ni       - asynchronous active-low reset
//               res_valid_i  - result valid level from the GCD slave
//               res_val_i    - result value
//               out_ready_i  - consumer ready
//               out_valid_o  - buffer not empty
//               out_data_o   - oldest buffered result (0 when empty)
//               count_o      - occupancy
//               full_o       - occupancy equals DEPTH
//               empty_o      - occupancy equals zero
//               drop_cnt_o   - saturating count of overflow losses
//               zero_seen_o  - sticky: an accepted result was 0
// Revision    : 1.0 - initial release
// ============================================================================
module gcd_result_collector
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH,
    parameter int DEPTH = RES_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     res_valid_i,
    input  logic [WIDTH-1:0]         res_val_i,
    input  logic                     out_ready_i,
    output logic                     out_valid_o,
    output logic [WIDTH-1:0]         out_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [DROP_W-1:0]        drop_cnt_o,
    output logic                     zero_seen_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic             r_valid_q;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_zero_seen;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_capture;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    fifo_op_e         w_op;

    // A result held valid for several cycles produces a single capture.
    assign w_capture = res_valid_i & ~r_valid_q;
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_pop     = ~w_empty & out_ready_i;
    // When full, a same-cycle pop frees the slot the new result goes into.
    assign w_push    = w_capture & (~w_full | w_pop);
    assign w_drop    = w_capture & w_full & ~w_pop;
    assign w_op      = fifo_op(w_push, w_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid_q   <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_zero_seen <= 1'b0;
        end else begin
            r_valid_q <= res_valid_i;
            // DEPTH is a power of two, so pointer overflow wraps modulo DEPTH.
            unique case (w_op)
                OP_PUSH: begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                    r_count  <= r_count + CNT_W'(1);
                end
                OP_POP: begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                    r_count  <= r_count - CNT_W'(1);
                end
                OP_BOTH: begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                default: ;
            endcase
            if (w_push && (res_val_i == '0)) begin
                r_zero_seen <= 1'b1;
            end
        end
    end

    // Data entries need no reset: the output is masked while empty.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= res_val_i;
        end
    end

    sat_counter #(
        .WIDTH (DROP_W)
    ) u_drop_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (w_drop),
        .count_o (drop_cnt_o)
    );

    assign out_valid_o = ~w_empty;
    assign out_data_o  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign count_o     = r_count;
    assign full_o      = w_full;
    assign empty_o     = w_empty;
    assign zero_seen_o = r_zero_seen;

endmodule
`default_nettype wire

// File: tb/tb_gcd_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_gcd_result_collector
// Description : Scoreboard bench for gcd_result_collector. A reference model
//               queues accepted results and tracks occupancy, drops and the
//               zero flag; a monitor compares the DUT against it every cycle
//               and retires entries as the consumer takes them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gcd_result_collector;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             res_valid = 1'b0;
    logic [WIDTH-1:0] res_val = '0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       count;
    logic             full;
    logic             empty;
    logic [7:0]       drop_cnt;
    logic             zero_seen;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_count = 0;
    int m_drop  = 0;
    bit m_zero  = 1'b0;
    bit m_prev  = 1'b0;
    int exp_q[$];

    gcd_result_collector #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .res_valid_i (res_valid),
        .res_val_i   (res_val),
        .out_ready_i (out_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .count_o     (count),
        .full_o      (full),
        .empty_o     (empty),
        .drop_cnt_o  (drop_cnt),
        .zero_seen_o (zero_seen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: applies the acceptance rules on every active edge.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_count = 0;
                m_drop  = 0;
                m_zero  = 1'b0;
                m_prev  = 1'b0;
                exp_q.delete();
            end else begin
                bit cap;
                bit pop;
                cap = res_valid && !m_prev;
                pop = (m_count > 0) && out_ready;
                if (cap) begin
                    if ((m_count < DEPTH) || pop) begin
                        exp_q.push_back(int'(res_val));
                        if (res_val == 0) m_zero = 1'b1;
                        m_count++;
                    end else if (m_drop < 255) begin
                        m_drop++;
                    end
                end
                if (pop) m_count--;
                m_prev = res_valid;
            end
        end
    end

    // Monitor: compares DUT outputs mid-cycle and retires consumed entries.
    initial begin
        forever begin
            @(negedge clk);
            chk("count", int'(count), m_count);
            chk("out_valid", int'(out_valid), int'(m_count != 0));
            chk("full", int'(full), int'(m_count == DEPTH));
            chk("empty", int'(empty), int'(m_count == 0));
            chk("drop_cnt", int'(drop_cnt), m_drop);
            chk("zero_seen", int'(zero_seen), int'(m_zero));
            if (m_count == 0) begin
                chk("data_idle", int'(out_data), 0);
            end else if (exp_q.size() > 0) begin
                chk("data", int'(out_data), exp_q[0]);
            end
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pop_underflow: got pop of %0d expected no entry at %0t",
                             out_data, $time);
                end else begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_val(input int v);
        res_valid = 1'b1;
        res_val   = WIDTH'(v);
        step();
        res_valid = 1'b0;
        step();
    endtask

    task automatic drain();
        out_ready = 1'b1;
        res_valid = 1'b0;
        repeat (DEPTH + 3) step();
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_count", int'(count), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_drop", int'(drop_cnt), 0);
        chk("rst_data", int'(out_data), 0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int order[6] = '{3, 5, 7, 1, 2, 4};

        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();

        // Level held for 5 cycles gives exactly one push
        res_valid = 1'b1;
        res_val   = 4'd6;
        repeat (5) step();
        res_valid = 1'b0;
        @(negedge clk);
        chk("edge_count", int'(count), 1);
        chk("edge_data", int'(out_data), 6);
        step();
        drain();

        // Ordering with toggling ready, pointers wrap past DEPTH
        foreach (order[i]) begin
            res_valid = 1'b1;
            res_val   = WIDTH'(order[i]);
            out_ready = ~out_ready;
            step();
            res_valid = 1'b0;
            out_ready = ~out_ready;
            step();
        end
        drain();

        // Mid-run reset with 3 entries, valid held high across release
        push_val(8);
        push_val(10);
        push_val(12);
        res_valid = 1'b1;
        res_val   = 4'd11;
        do_reset();
        step();
        res_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_count", int'(count), 1);
        chk("post_rst_data", int'(out_data), 11);
        step();
        drain();

        // Overflow
        do_reset();
        step();
        for (int v = 1; v <= 5; v++) push_val(v);
        @(negedge clk);
        chk("ovf_count", int'(count), 4);
        chk("ovf_full", int'(full), 1);
        chk("ovf_drop", int'(drop_cnt), 1);
        chk("ovf_head", int'(out_data), 1);
        step();

        // Full with simultaneous pop and capture
        out_ready = 1'b1;
        res_valid = 1'b1;
        res_val   = 4'd9;
        step();
        out_ready = 1'b0;
        res_valid = 1'b0;
        @(negedge clk);
        chk("fpp_count", int'(count), 4);
        chk("fpp_drop", int'(drop_cnt), 1);
        step();
        drain();

        // Zero result and drop saturation
        push_val(0);
        @(negedge clk);
        chk("zero_seen", int'(zero_seen), 1);
        step();
        drain();
        for (int i = 0; i < 300; i++) push_val(int'($urandom_range(1, 15)));
        @(negedge clk);
        chk("sat_drop", int'(drop_cnt), 255);
        step();
        drain();

        // Randomized traffic with occasional resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            res_valid = ($urandom_range(0, 2) == 0);
            res_val   = WIDTH'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0) ? ($urandom_range(0, 1) == 1) : 1'b0;
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                step();
            end
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
